debounce_sync: RTL and testbench
================================

DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Upstream input-conditioning stage. Takes a raw asynchronous level (switch or button), synchronises and debounces it, and produces the clean level and edge pulses that feed the d input of the downstream flip-flop stage.

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 50000, meaning the number of consecutive stable synchronised samples required to accept a new level; legal range 1 .. 2^CNT_W-1.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the stability counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port din, input, 1 bit: raw asynchronous level.
REQ-006 The block SHALL have port dout, output, 1 bit: debounced level (registered).
REQ-007 The block SHALL have port rise, output, 1 bit: one-cycle pulse when dout goes 0->1.
REQ-008 The block SHALL have port fall, output, 1 bit: one-cycle pulse when dout goes 1->0.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a candidate transition is being qualified.
REQ-010 The block SHALL have port glitch_cnt, output, 8 bits: count of aborted transitions; present only with DEBOUNCE_GLITCH_CNT_EN.

Function
REQ-011 din SHALL pass through a two-flop synchroniser, sync1 then sync2; only sync2 is used downstream.
REQ-012 The FSM SHALL have states IDLE_LO, WAIT_HI, IDLE_HI and WAIT_LO.
REQ-013 In IDLE_LO, sync2=1 SHALL move the FSM to WAIT_HI with cnt cleared to 0; otherwise it holds.
REQ-014 In WAIT_HI, sync2=0 SHALL return the FSM to IDLE_LO (glitch abort) with cnt cleared and dout unchanged.
REQ-015 In WAIT_HI, sync2=1 with cnt=STABLE_CYCLES-1 SHALL move the FSM to IDLE_HI, set dout=1 and assert rise for exactly one cycle.
REQ-016 In WAIT_HI, sync2=1 with cnt<STABLE_CYCLES-1 SHALL increment cnt.
REQ-017 IDLE_HI and WAIT_LO SHALL mirror REQ-013..016 with polarity inverted; acceptance sets dout=0 and pulses fall.
REQ-018 Latency: if din is first sampled high at edge n and stays high, dout=1 and rise=1 SHALL be visible after edge n+STABLE_CYCLES+2; the falling direction is symmetric.
REQ-019 busy SHALL equal 1 exactly while the state is WAIT_HI or WAIT_LO.
REQ-020 rise and fall SHALL never be asserted in the same cycle, and neither SHALL be asserted for two consecutive cycles.
REQ-021 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-022 With STABLE_CYCLES=1, acceptance SHALL occur on the first WAIT cycle in which sync2 is still at the new level.

Reset
REQ-023 While rst=1 at a clock edge: sync1, sync2, cnt, dout, rise, fall, busy and glitch_cnt SHALL all be 0, and the state SHALL be IDLE_LO.
REQ-024 rst SHALL take priority over every FSM transition, including an acceptance due in the same cycle.
REQ-025 A reset asserted mid-qualification SHALL discard the qualification; no rise or fall SHALL follow from it.
REQ-026 Qualification SHALL restart from sync2 sampling only after rst deasserts.

Configuration
REQ-027 With macro DEBOUNCE_GLITCH_CNT_EN defined, glitch_cnt SHALL increment by 1 on every abort per REQ-014 and its mirror, saturating at 255.
REQ-028 With DEBOUNCE_GLITCH_CNT_EN defined, glitch_cnt SHALL clear only on rst.
REQ-029 Without DEBOUNCE_GLITCH_CNT_EN, the glitch_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (STABLE_CYCLES=4)
REQ-030 The bench SHALL cover: din 0->1 first sampled at edge 10, held high -> dout=1 and rise=1 after edge 16 only; busy=1 after edges 12..15.
REQ-031 The bench SHALL cover: from dout=1, din low for 2 cycles then high again -> no fall, dout stays 1; glitch_cnt +1 when enabled.
REQ-032 The bench SHALL cover: din toggling every cycle for 100 cycles -> dout, rise and fall remain 0; glitch_cnt saturates at 255 after a long enough run, never wrapping to 0.
REQ-033 The bench SHALL cover: rst pulsed for 1 cycle while in WAIT_HI with cnt=2 -> all outputs 0 next cycle; with din still high, rise occurs 7 edges after rst deasserts (2 synchroniser edges, 1 edge into WAIT_HI, 4 qualification edges).
REQ-034 The bench SHALL cover: full high-then-low cycle -> exactly one rise and one fall pulse, each one cycle wide, never in the same cycle.
REQ-035 The bench SHALL cover: with STABLE_CYCLES=1, din held high from edge 10 -> dout=1 after edge 13.

Source files
------------

// File: rtl/debounce_sync.sv
// debounce_sync: two-flop synchroniser followed by a debounce FSM with registered level/edge outputs.
// Define DEBOUNCE_GLITCH_CNT_EN to add the saturating aborted-transition counter on glitch_cnt.
module debounce_sync #(
  parameter int unsigned STABLE_CYCLES = 50000,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic       dout,
  output logic       rise,
  output logic       fall,
`ifdef DEBOUNCE_GLITCH_CNT_EN
  output logic [7:0] glitch_cnt,
`endif
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE_LO,
    WAIT_HI,
    IDLE_HI,
    WAIT_LO
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_e           state_q;
  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dout_q;
  logic             rise_q;
  logic             fall_q;
  logic             busy_q;

  // cnt counts the WAIT-state samples already seen at the new level, so acceptance
  // lands on the STABLE_CYCLES-th consecutive such sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE_LO;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      unique case (state_q)
        IDLE_LO: begin
          if (sync2_q) begin
            state_q <= WAIT_HI;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        WAIT_HI: begin
          if (!sync2_q) begin
            state_q <= IDLE_LO;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE_HI;
            cnt_q   <= '0;
            dout_q  <= 1'b1;
            rise_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        IDLE_HI: begin
          if (!sync2_q) begin
            state_q <= WAIT_LO;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        WAIT_LO: begin
          if (sync2_q) begin
            state_q <= IDLE_HI;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE_LO;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            fall_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE_LO;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_q;
  logic       abort;

  assign abort = ((state_q == WAIT_HI) && !sync2_q) || ((state_q == WAIT_LO) && sync2_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_q <= '0;
    end else if (abort && (glitch_q != '1)) begin
      glitch_q <= glitch_q + 8'd1;
    end
  end

  assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench for debounce_sync: STABLE_CYCLES=4 and STABLE_CYCLES=1 instances share din/rst,
// checked every cycle against a run-length reference model plus directed latency/boundary checks.
module tb_debounce_sync;

  logic clk;
  logic rst;
  logic din;
  logic dout0, rise0, fall0, busy0;
  logic dout1, rise1, fall1, busy1;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] g0, g1;
`endif

  debounce_sync #(.STABLE_CYCLES(4), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .din(din),
    .dout(dout0), .rise(rise0), .fall(fall0),
`ifdef DEBOUNCE_GLITCH_CNT_EN
    .glitch_cnt(g0),
`endif
    .busy(busy0)
  );

  debounce_sync #(.STABLE_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .din(din),
    .dout(dout1), .rise(rise1), .fall(fall1),
`ifdef DEBOUNCE_GLITCH_CNT_EN
    .glitch_cnt(g1),
`endif
    .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       dout;
    logic       rise;
    logic       fall;
    logic       busy;
    logic [7:0] glitch;
  } obs_t;

  // Reference: last two din samples, accepted level, length of the current run of
  // synchronised samples differing from the accepted level, and aborted-run count.
  typedef struct {
    logic        d1;
    logic        d2;
    logic        dout;
    int unsigned run;
    int unsigned glitch;
  } mdl_t;

  mdl_t mdl[2];
  obs_t exp0_q[$];
  obs_t exp1_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic pr0 = 1'b0, pf0 = 1'b0, pr1 = 1'b0, pf1 = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step(input int idx, input logic d, input logic r,
                            input int unsigned s, output obs_t o);
    logic s2;
    o = '0;
    if (r) begin
      mdl[idx].d1     = 1'b0;
      mdl[idx].d2     = 1'b0;
      mdl[idx].dout   = 1'b0;
      mdl[idx].run    = 0;
      mdl[idx].glitch = 0;
    end else begin
      s2          = mdl[idx].d2;
      mdl[idx].d2 = mdl[idx].d1;
      mdl[idx].d1 = d;
      if (s2 != mdl[idx].dout) begin
        mdl[idx].run++;
        if (mdl[idx].run == s + 1) begin
          mdl[idx].dout = s2;
          mdl[idx].run  = 0;
          o.rise = s2;
          o.fall = !s2;
        end
      end else begin
        if (mdl[idx].run != 0 && mdl[idx].glitch < 255) mdl[idx].glitch++;
        mdl[idx].run = 0;
      end
    end
    o.dout   = mdl[idx].dout;
    o.busy   = (mdl[idx].run != 0);
    o.glitch = 8'(mdl[idx].glitch);
  endtask

  function automatic obs_t act(input int idx);
    obs_t a;
    a = '0;
    if (idx == 0) begin
      a.dout = dout0; a.rise = rise0; a.fall = fall0; a.busy = busy0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
      a.glitch = g0;
`endif
    end else begin
      a.dout = dout1; a.rise = rise1; a.fall = fall1; a.busy = busy1;
`ifdef DEBOUNCE_GLITCH_CNT_EN
      a.glitch = g1;
`endif
    end
    return a;
  endfunction

  task automatic cmp_obs(input string name, input obs_t a, input obs_t e);
    chk({name, "_dout"}, int'(a.dout), int'(e.dout));
    chk({name, "_rise"}, int'(a.rise), int'(e.rise));
    chk({name, "_fall"}, int'(a.fall), int'(e.fall));
    chk({name, "_busy"}, int'(a.busy), int'(e.busy));
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk({name, "_glitch"}, int'(a.glitch), int'(e.glitch));
`endif
  endtask

  // Driver: one call per clock edge; expected outputs of that edge go to the scoreboard.
  task automatic tick(input logic d, input logic r);
    obs_t o0, o1;
    @(negedge clk);
    din = d;
    rst = r;
    model_step(0, d, r, 4, o0);
    exp0_q.push_back(o0);
    model_step(1, d, r, 1, o1);
    exp1_q.push_back(o1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    repeat (3) tick(1'b0, 1'b0);
  endtask

  // Monitor: pops and compares every cycle, independent of the driver.
  initial begin : monitor
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp0_q.size() != 0) begin
        e = exp0_q.pop_front();
        cmp_obs("sb0", act(0), e);
      end
      if (exp1_q.size() != 0) begin
        e = exp1_q.pop_front();
        cmp_obs("sb1", act(1), e);
      end
      chk("excl0", int'(rise0 && fall0), 0);
      chk("excl1", int'(rise1 && fall1), 0);
      chk("width0", int'((rise0 && pr0) || (fall0 && pf0)), 0);
      chk("width1", int'((rise1 && pr1) || (fall1 && pf1)), 0);
      pr0 = rise0; pf0 = fall0; pr1 = rise1; pf1 = fall1;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin : driver
    int nr, nf;
    logic d;
    int len;
    rst = 1'b1;
    din = 1'b0;

    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    chk("rst_dout", int'(dout0 | dout1), 0);
    chk("rst_edges", int'(rise0 | fall0 | rise1 | fall1), 0);
    chk("rst_busy", int'(busy0 | busy1), 0);
    repeat (3) tick(1'b0, 1'b0);

    // Latency: first sample at k=0; S=4 accepts at k=6, S=1 at k=3.
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, 1'b0);
      chk("lat_rise", int'(rise0), int'(k == 6));
      chk("lat_dout", int'(dout0), int'(k >= 6));
      chk("lat_busy", int'(busy0), int'(k >= 2 && k <= 5));
      chk("lat1_dout", int'(dout1), int'(k >= 3));
      chk("lat1_rise", int'(rise1), int'(k == 3));
    end

    // Short low glitch from dout=1.
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick(1'b1, 1'b0);
      chk("glitch_nofall", int'(fall0), 0);
      chk("glitch_dout", int'(dout0), 1);
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("glitch_cnt1", int'(g0), 1);
`endif

    // Full high-then-low cycle.
    do_reset();
    nr = 0;
    nf = 0;
    for (int k = 0; k < 24; k++) begin
      tick(k < 12, 1'b0);
      nr += int'(rise0);
      nf += int'(fall0);
    end
    chk("one_rise", nr, 1);
    chk("one_fall", nf, 1);
    chk("cycle_dout", int'(dout0), 0);

    // Reset mid-qualification (WAIT_HI, cnt=2), din held high.
    do_reset();
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b0);
    chk("mid_busy", int'(busy0), 1);
    tick(1'b1, 1'b1);
    chk("mid_rst_out", int'({dout0, rise0, fall0, busy0}), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("mid_rst_glitch", int'(g0), 0);
`endif
    for (int k = 1; k <= 9; k++) begin
      tick(1'b1, 1'b0);
      chk("rst_lat_rise", int'(rise0), int'(k == 7));
      chk("rst_lat_dout", int'(dout0), int'(k >= 7));
    end

    // Toggling every cycle never qualifies; long enough to saturate the glitch counter.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      tick((i % 2) == 0, 1'b0);
      chk("tog_out0", int'({dout0, rise0, fall0}), 0);
      chk("tog_out1", int'({dout1, rise1, fall1}), 0);
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("tog_sat0", int'(g0), 255);
    chk("tog_sat1", int'(g1), 255);
`endif

    // Random runs of random length with occasional resets.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      d   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 9));
      for (int j = 0; j < len; j++) tick(d, $urandom_range(0, 199) == 0);
    end
    repeat (4) tick(1'b0, 1'b0);

    for (int i = 0; i < 4 && (exp0_q.size() != 0 || exp1_q.size() != 0); i++) @(negedge clk);
    chk("drain", exp0_q.size() + exp1_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
